// File: rtl/adder_share_sched_if.sv
// Request/response channel bundle for adder_share_sched.
// The master side is the client pool; the slave side is the scheduler.
interface adder_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_a;
  logic [3*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_cin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [3:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one 3b+3b+cin adder datapath among NUM_REQ clients.
// Define ADDER_SHARE_ERR_MON_EN to build the exact-sum mismatch monitor (rsp_err/err_cnt).
module adder_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_share_sched_if.slave  bus,
  output logic [6:0]          add_pi,
  input  logic [3:0]          add_po,
  output logic                busy,
  output logic [15:0]         err_cnt,
  output logic                rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [6:0]        add_pi_q, add_pi_d;
  logic [3:0]        rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [ID_W-1:0]   gnt_idx;
  logic [6:0]        gnt_op;
  logic              gnt_found;
  logic              sample_c;

  // Rank 0 is the requester right after rr_ptr; lowest valid rank wins.
  always_comb begin
    int best;
    int rank;
    best      = NUM_REQ;
    rank      = 0;
    gnt_idx   = '0;
    gnt_op    = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rank = (i > int'(rr_ptr_q)) ? (i - int'(rr_ptr_q) - 1)
                                  : (i - int'(rr_ptr_q) - 1 + NUM_REQ);
      if (bus.req_valid[i] && (rank < best)) begin
        best      = rank;
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
        gnt_op    = {bus.req_cin[i], bus.req_b[3*i +: 3], bus.req_a[3*i +: 3]};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_id_d    = rsp_id_q;
    lat_cnt_d   = lat_cnt_q;
    add_pi_d    = add_pi_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_c = '0;
    sample_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready_c[gnt_idx] = 1'b1;
          add_pi_d  = gnt_op;
          rr_ptr_d  = gnt_idx;
          rsp_id_d  = gnt_idx;
          lat_cnt_d = 3'(ADD_LAT - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == 3'd0) begin
          sample_c    = 1'b1;
          rsp_data_d  = add_po;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      rsp_id_q    <= '0;
      lat_cnt_q   <= '0;
      add_pi_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_id_q    <= rsp_id_d;
      lat_cnt_q   <= lat_cnt_d;
      add_pi_q    <= add_pi_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign add_pi        = add_pi_q;
  assign busy          = busy_q;

`ifdef ADDER_SHARE_ERR_MON_EN
  logic [3:0]  exact_c;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Reference sum is taken from the registered operands the datapath is seeing.
  always_comb begin
    exact_c   = {1'b0, add_pi_q[2:0]} + {1'b0, add_pi_q[5:3]} + {3'b000, add_pi_q[6]};
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
    if (sample_c) begin
      rsp_err_d = (add_po != exact_c);
      if ((add_po != exact_c) && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rsp_err = rsp_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign rsp_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_share_sched.sv
// Bench for adder_share_sched: directed steps, an ADD_LAT=3 instance, and
// randomized traffic checked against a transaction-level scheduler model.
module tb_adder_share_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_share_sched_if #(.NUM_REQ(4), .ID_W(2)) bus0 ();
  adder_share_sched_if #(.NUM_REQ(4), .ID_W(2)) bus1 ();

  logic [6:0]  add_pi0, add_pi1;
  logic [3:0]  add_po0, po1;
  logic        busy0, busy1, rsp_err0, rsp_err1;
  logic [15:0] err_cnt0, err_cnt1;
  logic        force0;

  // Exact adder stub on instance 0, with an override that forces a wrong sum.
  assign add_po0 = force0 ? 4'd0
                 : ({1'b0, add_pi0[2:0]} + {1'b0, add_pi0[5:3]} + {3'b000, add_pi0[6]});

  adder_share_sched #(.NUM_REQ(4), .ADD_LAT(1), .ID_W(2)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .add_pi(add_pi0), .add_po(add_po0),
    .busy(busy0), .err_cnt(err_cnt0), .rsp_err(rsp_err0));

  adder_share_sched #(.NUM_REQ(4), .ADD_LAT(3), .ID_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .add_pi(add_pi1), .add_po(po1),
    .busy(busy1), .err_cnt(err_cnt1), .rsp_err(rsp_err1));

`ifdef ADDER_SHARE_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: 0 idle, 1 waiting on adder, 2 response pending
  int mstate, last_g, pend, cur_id, cur_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input int i, input int a, input int b, input int c, input bit v);
    bus0.req_valid[i]     = v;
    bus0.req_a[3*i +: 3]  = 3'(a);
    bus0.req_b[3*i +: 3]  = 3'(b);
    bus0.req_cin[i]       = 1'(c);
  endtask

  task automatic run_phase(input int n, input bit all_valid);
    int g;
    int last_gcyc;
    bit anyv;
    logic [3:0] exp_ready;
    last_gcyc = -1;
    for (int cyc = 0; cyc < n; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == pend || !bus0.req_valid[i] || (!all_valid && $urandom_range(0, 7) == 0)) begin
          set_req0(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)),
                   all_valid ? 1'b1 : 1'($urandom_range(0, 1)));
        end
      end
      pend = -1;
      bus0.rsp_ready = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      anyv = |bus0.req_valid;
      g = -1;
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && bus0.req_valid[(last_g + k) % 4]) g = (last_g + k) % 4;
      end
      exp_ready = (mstate == 0 && anyv) ? 4'(1 << g) : 4'b0000;
      chk("rnd_req_ready", 32'(bus0.req_ready), 32'(exp_ready));
      chk("rnd_busy", 32'(busy0), 32'(mstate != 0));
      chk("rnd_rsp_valid", 32'(bus0.rsp_valid), 32'(mstate == 2));
      if (mstate == 2) begin
        chk("rnd_rsp_data", 32'(bus0.rsp_data), 32'(cur_sum));
        chk("rnd_rsp_id", 32'(bus0.rsp_id), 32'(cur_id));
        chk("rnd_rsp_err", 32'(rsp_err0), 32'd0);
      end
      case (mstate)
        0: if (anyv) begin
          cur_id  = g;
          cur_sum = int'(bus0.req_a[3*g +: 3]) + int'(bus0.req_b[3*g +: 3])
                  + int'(bus0.req_cin[g]);
          if (all_valid && last_gcyc >= 0) chk("grant_gap", 32'(cyc - last_gcyc), 32'd3);
          last_gcyc = cyc;
          last_g    = g;
          pend      = g;
          mstate    = 1;
        end
        1: mstate = 2;
        default: if (bus0.rsp_ready) mstate = 0;
      endcase
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    force0 = 1'b0;
    bus0.req_valid = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.req_cin = '0;
    bus0.rsp_ready = 1'b0;
    bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_cin = '0;
    bus1.rsp_ready = 1'b0;
    po1 = 4'h5;
    repeat (3) tick();
    chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt0), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err0), 32'd0);
    chk("rst_req_ready", 32'(bus0.req_ready), 32'd0);
    chk("rst_add_pi", 32'(add_pi0), 32'd0);
    chk("rst_rsp_data", 32'(bus0.rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(bus0.rsp_id), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 2
    set_req0(2, 3, 5, 1, 1'b1);
    #1;
    chk("single_ready", 32'(bus0.req_ready), 32'b0100);
    tick();
    bus0.req_valid[2] = 1'b0;
    set_req0(1, 2, 1, 0, 1'b1);
    #1;
    chk("single_add_pi", 32'(add_pi0), 32'b1101011);
    chk("wait_busy", 32'(busy0), 32'd1);
    chk("wait_ready", 32'(bus0.req_ready), 32'd0);
    chk("wait_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    tick();
    chk("single_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    chk("single_rsp_data", 32'(bus0.rsp_data), 32'd9);
    chk("single_rsp_id", 32'(bus0.rsp_id), 32'd2);

    // Backpressure: response held while requester 1 waits
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(bus0.rsp_data), 32'd9);
      chk("bp_rsp_id", 32'(bus0.rsp_id), 32'd2);
      chk("bp_req_ready", 32'(bus0.req_ready), 32'd0);
      chk("bp_busy", 32'(busy0), 32'd1);
      chk("bp_add_pi", 32'(add_pi0), 32'b1101011);
    end
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    chk("accept_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    #1;
    chk("after_accept_ready", 32'(bus0.req_ready), 32'b0010);
    tick();
    bus0.req_valid[1] = 1'b0;
    chk("second_add_pi", 32'(add_pi0), 32'b0001010);
    tick();
    chk("second_rsp_data", 32'(bus0.rsp_data), 32'd3);
    chk("second_rsp_id", 32'(bus0.rsp_id), 32'd1);
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;

    // Reset in the middle of WAIT, then first grant goes to requester 0
    for (int i = 0; i < 4; i++) set_req0(i, 1, 1, 0, 1'b1);
    #1;
    chk("rr_after_1", 32'(bus0.req_ready), 32'b0100);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt0), 32'd0);
    chk("midrst_add_pi", 32'(add_pi0), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("postrst_first_grant", 32'(bus0.req_ready), 32'b0001);
    bus0.req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // ADD_LAT=3: adder output changes one cycle before the sample edge
    bus1.req_valid[0] = 1'b1;
    bus1.req_a[2:0] = 3'd1;
    bus1.req_b[2:0] = 3'd2;
    bus1.req_cin[0] = 1'b0;
    #1;
    chk("lat3_ready", 32'(bus1.req_ready), 32'b0001);
    tick();
    bus1.req_valid[0] = 1'b0;
    chk("lat3_add_pi", 32'(add_pi1), 32'b0010001);
    tick();
    po1 = 4'h6;
    chk("lat3_e1_valid", 32'(bus1.rsp_valid), 32'd0);
    tick();
    chk("lat3_e2_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("lat3_e2_busy", 32'(busy1), 32'd1);
    po1 = 4'hA;
    tick();
    chk("lat3_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
    chk("lat3_rsp_data", 32'(bus1.rsp_data), 32'hA);
    chk("lat3_rsp_id", 32'(bus1.rsp_id), 32'd0);
    chk("lat3_rsp_err", 32'(rsp_err1), 32'(MON));
    chk("lat3_err_cnt", 32'(err_cnt1), 32'(MON));
    po1 = 4'h3;
    tick();
    chk("lat3_hold_data", 32'(bus1.rsp_data), 32'hA);
    bus1.rsp_ready = 1'b1;
    tick();
    bus1.rsp_ready = 1'b0;
    chk("lat3_done_valid", 32'(bus1.rsp_valid), 32'd0);

    // Randomized traffic against the model, starting from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mstate = 0;
    last_g = 3;
    pend   = -1;
    run_phase(20, 1'b1);
    run_phase(80, 1'b0);
    bus0.req_valid = '0;
    bus0.rsp_ready = 1'b1;
    repeat (4) tick();

    // Mismatch monitor: forced-zero adder output
    force0 = 1'b1;
    set_req0(1, 7, 7, 1, 1'b1);
    #1;
    chk("err_grant", 32'(bus0.req_ready), 32'b0010);
    tick();
    bus0.req_valid = '0;
    tick();
    chk("err_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    chk("err_rsp_data", 32'(bus0.rsp_data), 32'd0);
    chk("err_rsp_err", 32'(rsp_err0), 32'(MON));
    chk("err_cnt_inc", 32'(err_cnt0), 32'(MON));
    tick();
    set_req0(0, 0, 0, 0, 1'b1);
    #1;
    tick();
    bus0.req_valid = '0;
    tick();
    chk("ok_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    chk("ok_rsp_err", 32'(rsp_err0), 32'd0);
    chk("ok_err_cnt", 32'(err_cnt0), 32'(MON));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Round-robin scheduler that time-shares one combinational adder_6-class datapath (7 inputs, 4 outputs: 3b+3b+cin -> 4b sum) among NUM_REQ requesters.
- Registers the granted operands onto the datapath and samples the result after ADD_LAT cycles.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between client logic and an approximate or exact adder instance, so one adder serves several producers.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADD_LAT, 1, cycles from add_pi update to add_po sample (1..7)
ID_W, 2, width of rsp_id; must equal ceil(log2(NUM_REQ))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept strobe
req_a  in  3*NUM_REQ  operand A, requester i at [3i+2:3i]
req_b  in  3*NUM_REQ  operand B, same packing
req_cin  in  NUM_REQ  carry-in per requester
add_pi  out  7  datapath inputs: [2:0]=A, [5:3]=B, [6]=cin
add_po  in  4  datapath sum output
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  4  sampled sum
rsp_id  out  ID_W  index of the served requester
busy  out  1  high whenever state != IDLE
err_cnt  out  16  mismatch counter (see Optional Feature)
rsp_err  out  1  response mismatched the exact sum

Behaviour:
- Reset (async assert, sync release): state=IDLE; add_pi=0; rsp_valid=0; rsp_data=0; rsp_id=0; req_ready=0; busy=0; err_cnt=0; rsp_err=0; rr_ptr=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit scanning from rr_ptr+1 upward, modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle; it is the only ready asserted.
  - On the edge: add_pi <= {cin_g, b_g, a_g}; rr_ptr <= g; rsp_id <= g; lat_cnt <= ADD_LAT-1; state -> WAIT.
  - No valid: stay in IDLE; add_pi holds its last value.
- WAIT:
  - If lat_cnt==0: rsp_data <= add_po, state -> RESP. Otherwise decrement lat_cnt.
  - With ADD_LAT=1, add_po is sampled on the first edge after the add_pi load.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On rsp_valid&&rsp_ready: state -> IDLE, rsp_valid deasserts next cycle.
  - No new grant is issued while in WAIT or RESP; req_ready=0 there.
- Throughput: one operation per ADD_LAT+2 cycles with rsp_ready held high. Grant-to-rsp_valid latency = ADD_LAT+1 edges.
- Requests are level-sensitive:
  - A requester holds req_valid and its operands until it sees req_ready.
  - Withdrawing req_valid before the grant is legal; the request is not served.
- Fairness: with all valid continuously, grant order is 0,1,..,NUM_REQ-1,0,...
- Operand changes on add_pi occur only at grant edges; add_pi is stable through WAIT and RESP.
- Reset mid-operation aborts the in-flight op with no response. Post-reset state is identical to power-up.
- req_valid bits at index >= NUM_REQ do not exist. X on non-granted operands has no effect.

Optional Feature:
- Macro: ADDER_SHARE_ERR_MON_EN.
- Defined:
  - The block computes the exact sum {1'b0,a}+{1'b0,b}+cin (4b) from the captured add_pi.
  - At the add_po sample edge, rsp_err <= (add_po != exact).
  - err_cnt increments by 1 on each mismatch and saturates at 16'hFFFF.
  - err_cnt is cleared only by reset.
- Undefined: no exact-sum logic is built; rsp_err and err_cnt are tied to 0. Ports remain present.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> rsp_valid=0, busy=0, err_cnt=0 immediately. First grant after release goes to requester 0 when all valid.
- Single request, exact adder model, ADD_LAT=1: req 2 sends a=3, b=5, cin=1 -> req_ready=4'b0100 for one cycle; add_pi=7'b1101011; rsp_valid 2 edges later with rsp_data=9, rsp_id=2.
- All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0; one response every 3 cycles; rsp_id sequence matches.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_id stable; req_ready stays 0; busy=1; next grant only after the accept.
- ADD_LAT=3: add_po model changes value one cycle before the sample edge -> rsp_data equals the value present at edge ADD_LAT after the load.
- With ADDER_SHARE_ERR_MON_EN, stub add_po forced to 4'b0000 for a=7, b=7, cin=1 (exact 15) -> rsp_err=1 and err_cnt increments by 1. For a=0, b=0, cin=0 -> rsp_err=0 and err_cnt is unchanged.
